display_multiplexer: RTL and testbench
======================================

DISPLAY_MULTIPLEXER -- requirements
Module: display_multiplexer

Interface
REQ-001 Parameter REFRESH_CYCLES, default 50000, number of clk cycles each digit stays selected; legal range 1 to 2^20.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  single rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port BCD_code  input  28  packed BCD word; [27:24] thousands, [23:20] hundreds, [19:16] tens, [15:12] units; [11:0] ignored.
REQ-006 Port segments  output  7  active-low segment drive {g,f,e,d,c,b,a}.
REQ-007 Port display_select  output  4  active-low one-hot digit enable.

Function
REQ-008 Internal 4-bit signals thousands, hundreds, tens and units SHALL be continuous slices of BCD_code per REQ-005, with no register stage.
REQ-009 Internal 2-bit register current_display SHALL select the active digit: 0 = units, 1 = tens, 2 = hundreds, 3 = thousands.
REQ-010 display_select SHALL be combinational from current_display: 0->1110, 1->1101, 2->1011, 3->0111.
REQ-011 segments SHALL be combinational from current_display and the selected digit, so a change of current_display is reflected with zero cycles of latency.
REQ-012 Digit encoding (active-low) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-013 A nibble value of 10 to 15 SHALL display a dash, segments=0111111.
REQ-014 A refresh counter SHALL count 0 to REFRESH_CYCLES-1; on its terminal count it SHALL wrap to 0 and current_display SHALL advance by 1 on the same edge.
REQ-015 current_display SHALL wrap from 3 to 0.
REQ-016 With REFRESH_CYCLES=1, current_display SHALL advance every cycle.
REQ-017 BCD_code changes SHALL appear on segments immediately for the currently selected digit, and SHALL NOT disturb the counter or scan order.
REQ-018 Exactly one bit of display_select SHALL be low at all times, including during and immediately after reset.

Reset
REQ-019 When reset is high at a rising clk edge, the counter and current_display SHALL both become 0.
REQ-020 After reset: display_select=1110; segments SHALL show the units digit, or the REQ-023 blanking result.
REQ-021 Reset asserted mid-scan SHALL abort the current dwell and restart at the units digit with a full REFRESH_CYCLES dwell.
REQ-022 Reset SHALL take priority over the counter terminal count when both occur at the same edge.

Configuration
REQ-023 Macro DISPLAY_MUX_BLANK_EN, when defined, SHALL enable leading-zero blanking: segments=1111111 for a digit that is 0 and has only zero digits above it.
- thousands is blanked if 0.
- hundreds is blanked if it and thousands are 0.
- tens is blanked if it, hundreds and thousands are 0.
- units is never blanked.
REQ-024 Without DISPLAY_MUX_BLANK_EN, all four digits SHALL always be decoded per REQ-012 and REQ-013.
REQ-025 display_select behaviour SHALL be identical with and without the macro.

Verification
REQ-026 BCD_code=0x1234000, force current_display to 0,1,2,3 -> display_select 1110/1101/1011/0111; segments 0011001/0110000/0100100/1111001; thousands=1, hundreds=2, tens=3, units=4.
REQ-027 BCD_code=0x0786000, current_display=3 -> segments=1000000 without the macro, 1111111 with DISPLAY_MUX_BLANK_EN; units=6 -> 0000010.
REQ-028 REFRESH_CYCLES=4, free-running -> current_display advances every 4 cycles, sequence 0,1,2,3,0; display_select is always one-hot-low.
REQ-029 Assert reset while current_display=2 and the counter is mid-count -> next edge gives current_display=0, display_select=1110, and 4 cycles dwell before advancing.
REQ-030 BCD_code units nibble=0xA -> segments=0111111 when current_display=0.
REQ-031 Reset coincident with terminal count -> current_display=0, not 1.

Source files
------------

// File: rtl/display_multiplexer.sv
// display_multiplexer: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. It scans units, tens, hundreds, thousands in turn,
// holding each digit for REFRESH_CYCLES clocks. Segments and digit enables
// are active-low.
// Optional build macro: DISPLAY_MUX_BLANK_EN enables leading-zero blanking.
module display_multiplexer #(
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [27:0] BCD_code,
    output logic [6:0]  segments,
    output logic [3:0]  display_select
);

    // Width chosen so the counter can hold REFRESH_CYCLES-1 (minimum 1 bit).
    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [3:0]    thousands, hundreds, tens, units;
    logic [CW-1:0] refresh_count;
    logic [1:0]    current_display;
    logic [3:0]    digit;
    logic          blank;
    logic          unused_bits;

    assign thousands   = BCD_code[27:24];
    assign hundreds    = BCD_code[23:20];
    assign tens        = BCD_code[19:16];
    assign units       = BCD_code[15:12];
    assign unused_bits = ^BCD_code[11:0];

    // Dwell counter; the digit index steps on the same edge the counter wraps.
    // Reset wins over the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_count   <= '0;
            current_display <= 2'd0;
        end else if (refresh_count == LAST) begin
            refresh_count   <= '0;
            current_display <= current_display + 2'd1;
        end else begin
            refresh_count   <= refresh_count + CW'(1);
        end
    end

    // One-hot-low digit enable straight from the digit index.
    always_comb begin
        case (current_display)
            2'd0:    display_select = 4'b1110;
            2'd1:    display_select = 4'b1101;
            2'd2:    display_select = 4'b1011;
            default: display_select = 4'b0111;
        endcase
    end

    // Pick the nibble for the active digit and decide whether it is blanked.
    always_comb begin
        case (current_display)
            2'd0:    digit = units;
            2'd1:    digit = tens;
            2'd2:    digit = hundreds;
            default: digit = thousands;
        endcase
`ifdef DISPLAY_MUX_BLANK_EN
        // A digit is a leading zero when it and every digit above it are 0;
        // the units digit always shows.
        case (current_display)
            2'd1:    blank = (tens == 4'd0) && (hundreds == 4'd0) && (thousands == 4'd0);
            2'd2:    blank = (hundreds == 4'd0) && (thousands == 4'd0);
            2'd3:    blank = (thousands == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    // Active-low 7-segment decode {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
    always_comb begin
        if (blank) begin
            segments = 7'b1111111;
        end else begin
            case (digit)
                4'd0:    segments = 7'b1000000;
                4'd1:    segments = 7'b1111001;
                4'd2:    segments = 7'b0100100;
                4'd3:    segments = 7'b0110000;
                4'd4:    segments = 7'b0011001;
                4'd5:    segments = 7'b0010010;
                4'd6:    segments = 7'b0000010;
                4'd7:    segments = 7'b1111000;
                4'd8:    segments = 7'b0000000;
                4'd9:    segments = 7'b0010000;
                default: segments = 7'b0111111;
            endcase
        end
    end

endmodule

// File: tb/tb_display_multiplexer.sv
// Bench for display_multiplexer with a 4-cycle dwell. The reference model
// tracks the number of clock edges since the last reset edge and derives the
// active digit as (edges / R) mod 4, then looks the glyph up in a table.
module tb_display_multiplexer;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [27:0] BCD_code = 28'h1234000;
    logic [6:0]  segments;
    logic [3:0]  display_select;

    int checks = 0;
    int failures = 0;
    int k = 0;

    logic [6:0] glyph [16];

    display_multiplexer #(.REFRESH_CYCLES(R)) dut (
        .clk           (clk),
        .reset         (reset),
        .BCD_code      (BCD_code),
        .segments      (segments),
        .display_select(display_select)
    );

    always #5 clk = ~clk;

    function automatic int cur_dig();
        return (k / R) % 4;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [27:0] code, input int d);
        logic [3:0] nib [4];
        bit lead;
        for (int i = 0; i < 4; i++) nib[i] = code[12 + 4*i +: 4];
        lead = 1'b0;
`ifdef DISPLAY_MUX_BLANK_EN
        lead = (d != 0);
        for (int i = d; i < 4; i++) if (nib[i] != 4'd0) lead = 1'b0;
`endif
        return lead ? 7'b1111111 : glyph[nib[d]];
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Compare both outputs against the model.
    task automatic check_model(input string tag);
        int d;
        d = cur_dig();
        check({tag, "_sel"}, {3'b000, display_select}, {3'b000, ~(4'b0001 << d)});
        check({tag, "_onehot"}, 7'($countones(~display_select)), 7'd1);
        check({tag, "_seg"}, segments, exp_seg(BCD_code, d));
    endtask

    // Advance one clock edge, update the model, check at the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (reset) k = 0; else k++;
        @(negedge clk);
        check_model(tag);
    endtask

    // Step until the model reaches digit d at dwell offset off (bounded).
    task automatic run_to(input int d, input int off);
        int n;
        n = 0;
        while (!(cur_dig() == d && (k % R) == off) && n < 40) begin
            step("run");
            n++;
        end
        checks++;
        assert (n < 40) else begin
            failures++;
            $error("FAIL run_to_timeout observed=%0d expected=<40", n);
        end
    endtask

    initial begin
        logic [6:0] t26 [4];
        glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) glyph[i] = 7'b0111111;
        t26[0] = 7'b0011001; t26[1] = 7'b0110000; t26[2] = 7'b0100100; t26[3] = 7'b1111001;

        // Reset state
        step("reset0");
        step("reset1");
        check("reset_sel", {3'b000, display_select}, 7'b0001110);
        check("reset_seg", segments, 7'b0011001);
        reset = 1'b0;

        // Free-running scan of 0x1234: two full rotations with fixed glyphs
        for (int i = 0; i < 2*4*R; i++) begin
            step("scan");
            check("scan_fixed", segments, t26[cur_dig()]);
        end

        // Leading zero on thousands, then the units digit
        BCD_code = 28'h0786000;
        #1 check_model("bcd_change");
        run_to(3, 0);
`ifdef DISPLAY_MUX_BLANK_EN
        check("thousands_zero", segments, 7'b1111111);
`else
        check("thousands_zero", segments, 7'b1000000);
`endif
        run_to(0, 0);
        check("units_six", segments, 7'b0000010);

        // Non-BCD units nibble shows a dash
        BCD_code = 28'h000A000;
        #1 check("units_dash", segments, 7'b0111111);
        step("dash");

        // Reset mid-dwell on hundreds: full dwell on units afterwards
        BCD_code = 28'h1234000;
        run_to(2, 1);
        reset = 1'b1;
        step("mid_reset");
        reset = 1'b0;
        check("mid_reset_sel", {3'b000, display_select}, 7'b0001110);
        for (int i = 0; i < R - 1; i++) begin
            step("dwell");
            check("dwell_sel", {3'b000, display_select}, 7'b0001110);
        end
        step("advance");
        check("advance_sel", {3'b000, display_select}, 7'b0001101);

        // Reset coincident with terminal count
        run_to(0, R - 1);
        reset = 1'b1;
        step("tc_reset");
        reset = 1'b0;
        check("tc_reset_sel", {3'b000, display_select}, 7'b0001110);

        // Random BCD words (biased toward zeros) and occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) begin
                logic [27:0] c;
                c = 28'($urandom);
                for (int j = 0; j < 4; j++)
                    if ($urandom_range(2) == 0) c[12 + 4*j +: 4] = 4'd0;
                BCD_code = c;
                #1 check_model("rand_bcd");
            end
            reset = ($urandom_range(24) == 0);
            step("rand");
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
